// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer for the single-cycle core: sole owner of core
// clock enable and core reset, with a PC breakpoint and retired-instruction counter.
module cpu_run_controller #(
   parameter int ADDR_W     = 32,
   parameter int RESET_HOLD = 4,
   parameter int CNT_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_run_btn,
   input  logic              i_step_btn,
   input  logic              i_clear_btn,
   input  logic              i_bp_en,
   input  logic [ADDR_W-1:0] i_bp_addr,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_clk_enable,
   output logic              o_core_rst,
   output logic [2:0]        o_state,
   output logic [CNT_W-1:0]  o_instr_count,
   output logic              o_bp_hit
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bp_hit_q, bp_hit_d;
   logic              skip_q, skip_d;
   logic              mode_run_q, mode_run_d;
   logic              bp_match;
   logic              core_rst;
   logic              clk_en;

   // Skip masks the breakpoint for the first executed instruction after a resume,
   // so the instruction sitting at the breakpoint PC can retire.
   always_comb begin
      bp_match = i_bp_en & (i_pc == i_bp_addr) & ~skip_q;
      core_rst = (state_q == ST_IDLE) | (state_q == ST_PRE);
      clk_en   = 1'b0;
      case (state_q)
         ST_RUN:  clk_en = ~bp_match;
         ST_STEP: clk_en = 1'b1;
         default: clk_en = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = '0;
      cnt_d      = cnt_q;
      bp_hit_d   = bp_hit_q;
      skip_d     = skip_q;
      mode_run_d = mode_run_q;

      if (clk_en && !core_rst && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
      if ((state_q == ST_RUN) && clk_en)
         skip_d = 1'b0;

      if (i_clear_btn) begin
         state_d  = ST_IDLE;
         bp_hit_d = 1'b0;
         skip_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_run_btn || i_step_btn) begin
                  state_d    = ST_PRE;
                  mode_run_d = i_run_btn;
                  cnt_d      = '0;
                  bp_hit_d   = 1'b0;
                  skip_d     = 1'b0;
               end
            end
            ST_PRE: begin
               if (hold_q == HOLD_LAST)
                  state_d = mode_run_q ? ST_RUN : ST_STEP;
               else
                  hold_d = hold_q + 1'b1;
            end
            ST_RUN: begin
               if (bp_match) begin
                  state_d  = ST_HALT;
                  bp_hit_d = 1'b1;
               end else if (i_run_btn) begin
                  state_d = ST_HALT;
               end
            end
            ST_STEP: state_d = ST_HALT;
            ST_HALT: begin
               if (i_run_btn) begin
                  state_d  = ST_RUN;
                  skip_d   = 1'b1;
                  bp_hit_d = 1'b0;
               end else if (i_step_btn) begin
                  state_d  = ST_STEP;
                  bp_hit_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         cnt_q      <= '0;
         bp_hit_q   <= 1'b0;
         skip_q     <= 1'b0;
         mode_run_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         bp_hit_q   <= bp_hit_d;
         skip_q     <= skip_d;
         mode_run_q <= mode_run_d;
      end
   end

   assign o_clk_enable  = clk_en;
   assign o_core_rst    = core_rst;
   assign o_state       = state_q;
   assign o_instr_count = cnt_q;
   assign o_bp_hit      = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: the driver queues hand-computed expected
// outputs, a monitor pops and compares them at the falling edge or on reset assertion.
`timescale 1ns/1ps
module tb_cpu_run_controller;

   localparam int W = 38;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_run_btn;
   logic        i_step_btn;
   logic        i_clear_btn;
   logic        i_bp_en;
   logic [31:0] i_bp_addr;
   logic [31:0] i_pc;
   logic        o_clk_enable;
   logic        o_core_rst;
   logic [2:0]  o_state;
   logic [31:0] o_instr_count;
   logic        o_bp_hit;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks;
   int           errors;

   cpu_run_controller #(.ADDR_W(32), .RESET_HOLD(4), .CNT_W(32)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_run_btn     (i_run_btn),
      .i_step_btn    (i_step_btn),
      .i_clear_btn   (i_clear_btn),
      .i_bp_en       (i_bp_en),
      .i_bp_addr     (i_bp_addr),
      .i_pc          (i_pc),
      .o_clk_enable  (o_clk_enable),
      .o_core_rst    (o_core_rst),
      .o_state       (o_state),
      .o_instr_count (o_instr_count),
      .o_bp_hit      (o_bp_hit)
   );

   // clock / reset
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // driver tasks
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic exp_push(input string nm, input logic [2:0] st, input logic rst,
                           input logic en, input logic hit, input logic [31:0] cnt);
      exp_q.push_back({st, rst, en, hit, cnt});
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   always begin
      @(negedge i_clk or negedge i_rst_n);
      #0.1;
      while (exp_q.size() > 0) begin
         logic [W-1:0] e;
         logic [W-1:0] a;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {o_state, o_core_rst, o_clk_enable, o_bp_hit, o_instr_count};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%0d rst=%b en=%b hit=%b cnt=%0d, want st=%0d rst=%b en=%b hit=%b cnt=%0d",
                     nm, a[37:35], a[34], a[33], a[32], a[31:0],
                     e[37:35], e[34], e[33], e[32], e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      checks = 0; errors = 0;
      i_rst_n = 1'b0; i_run_btn = 1'b0; i_step_btn = 1'b0; i_clear_btn = 1'b0;
      i_bp_en = 1'b0; i_bp_addr = 32'h10; i_pc = 32'h0;
      repeat (2) @(posedge i_clk);
      #1;
      exp_push("in_reset", 3'd0, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      i_rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_push("reset_idle", 3'd0, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      end

      // run from IDLE, free run, run pulse halts after executing that cycle
      i_run_btn = 1'b1;
      exp_push("idle_run", 3'd0, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      i_run_btn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_push("pre_hold", 3'd1, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      end
      for (int k = 0; k < 10; k++) begin
         i_pc = 32'(4 * k);
         exp_push("run_exec", 3'd2, 1'b0, 1'b1, 1'b0, 32'(k)); cyc();
      end
      i_run_btn = 1'b1;
      exp_push("run_pulse", 3'd2, 1'b0, 1'b1, 1'b0, 32'd10); cyc();
      i_run_btn = 1'b0;
      exp_push("halt_after_run", 3'd4, 1'b0, 1'b0, 1'b0, 32'd11); cyc();
      exp_push("halt_hold", 3'd4, 1'b0, 1'b0, 1'b0, 32'd11); cyc();

      // clear, restart, breakpoint at 0x10
      i_clear_btn = 1'b1;
      exp_push("halt_clear", 3'd4, 1'b0, 1'b0, 1'b0, 32'd11); cyc();
      i_clear_btn = 1'b0;
      i_bp_en = 1'b1; i_pc = 32'h0; i_run_btn = 1'b1;
      exp_push("idle_hold_cnt", 3'd0, 1'b1, 1'b0, 1'b0, 32'd11); cyc();
      i_run_btn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_push("pre_clears_cnt", 3'd1, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      end
      for (int k = 0; k < 4; k++) begin
         i_pc = 32'(4 * k);
         exp_push("run_to_bp", 3'd2, 1'b0, 1'b1, 1'b0, 32'(k)); cyc();
      end
      i_pc = 32'h10;
      exp_push("bp_match", 3'd2, 1'b0, 1'b0, 1'b0, 32'd4); cyc();
      exp_push("bp_halt", 3'd4, 1'b0, 1'b0, 1'b1, 32'd4); cyc();
      i_run_btn = 1'b1;
      exp_push("bp_halt_run", 3'd4, 1'b0, 1'b0, 1'b1, 32'd4); cyc();
      i_run_btn = 1'b0;
      exp_push("resume_skip", 3'd2, 1'b0, 1'b1, 1'b0, 32'd4); cyc();
      i_pc = 32'h14;
      exp_push("resume_run", 3'd2, 1'b0, 1'b1, 1'b0, 32'd5); cyc();
      i_pc = 32'h18; i_run_btn = 1'b1;
      exp_push("resume_halt", 3'd2, 1'b0, 1'b1, 1'b0, 32'd6); cyc();
      i_run_btn = 1'b0; i_pc = 32'h1C;
      exp_push("halt_7", 3'd4, 1'b0, 1'b0, 1'b0, 32'd7); cyc();

      // three single steps, the last one sitting on the breakpoint PC
      for (int s = 0; s < 3; s++) begin
         i_step_btn = 1'b1;
         exp_push("step_press", 3'd4, 1'b0, 1'b0, 1'b0, 32'(7 + s)); cyc();
         i_step_btn = 1'b0;
         i_pc = (s == 2) ? 32'h10 : 32'(32'h1C + 4 * s);
         exp_push("step_exec", 3'd3, 1'b0, 1'b1, 1'b0, 32'(7 + s)); cyc();
         for (int k = 0; k < 4; k++) begin
            exp_push("step_halt", 3'd4, 1'b0, 1'b0, 1'b0, 32'(8 + s)); cyc();
         end
      end

      // run+step together in HALT resumes running, then clear mid-RUN
      i_run_btn = 1'b1; i_step_btn = 1'b1;
      exp_push("halt_both", 3'd4, 1'b0, 1'b0, 1'b0, 32'd10); cyc();
      i_run_btn = 1'b0; i_step_btn = 1'b0;
      exp_push("both_run_skip", 3'd2, 1'b0, 1'b1, 1'b0, 32'd10); cyc();
      i_pc = 32'h14;
      exp_push("run_after_both", 3'd2, 1'b0, 1'b1, 1'b0, 32'd11); cyc();
      i_clear_btn = 1'b1; i_pc = 32'h18;
      exp_push("run_clear", 3'd2, 1'b0, 1'b1, 1'b0, 32'd12); cyc();
      i_clear_btn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_push("clear_idle", 3'd0, 1'b1, 1'b0, 1'b0, 32'd13); cyc();
      end

      // step from IDLE
      i_step_btn = 1'b1; i_pc = 32'h0;
      exp_push("idle_step", 3'd0, 1'b1, 1'b0, 1'b0, 32'd13); cyc();
      i_step_btn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_push("pre_step", 3'd1, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      end
      exp_push("step_once", 3'd3, 1'b0, 1'b1, 1'b0, 32'd0); cyc();
      exp_push("step_halt_cnt", 3'd4, 1'b0, 1'b0, 1'b0, 32'd1); cyc();

      // async reset in the middle of STEP
      i_step_btn = 1'b1;
      exp_push("halt_step2", 3'd4, 1'b0, 1'b0, 1'b0, 32'd1); cyc();
      i_step_btn = 1'b0;
      exp_push("step2", 3'd3, 1'b0, 1'b1, 1'b0, 32'd1);
      @(negedge i_clk);
      #1;
      exp_push("rst_mid_step", 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
      i_rst_n = 1'b0;
      cyc();
      i_rst_n = 1'b1;

      // run+step together in IDLE picks RUN mode
      i_run_btn = 1'b1; i_step_btn = 1'b1;
      exp_push("post_reset", 3'd0, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      i_run_btn = 1'b0; i_step_btn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_push("pre_both", 3'd1, 1'b1, 1'b0, 1'b0, 32'd0); cyc();
      end
      i_clear_btn = 1'b1;
      exp_push("both_mode_run", 3'd2, 1'b0, 1'b1, 1'b0, 32'd0); cyc();
      i_clear_btn = 1'b0;
      exp_push("final_idle", 3'd0, 1'b1, 1'b0, 1'b0, 32'd1); cyc();
      cyc();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Run/halt/single-step sequencer for the single-cycle RV core. Sits between the debounced one-pulse buttons and the core's clock-enable and reset inputs.
- Adds a hardware PC breakpoint and a retired-instruction counter.
- Replaces the bare enable-toggle flop as the single owner of core enable and core reset.

Parameters:
- ADDR_W, 32, width of PC and breakpoint address.
- RESET_HOLD, 4, cycles core reset stays asserted in PRE before first execution (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_run_btn  in  1  one-cycle pulse; start from IDLE / toggle RUN<->HALT.
- i_step_btn  in  1  one-cycle pulse; execute exactly one instruction.
- i_clear_btn  in  1  one-cycle pulse; return to IDLE (core held in reset).
- i_bp_en  in  1  breakpoint enable (level).
- i_bp_addr  in  ADDR_W  breakpoint PC.
- i_pc  in  ADDR_W  PC of instruction executing this cycle (from datapath PC register).
- o_clk_enable  out  1  core clock enable.
- o_core_rst  out  1  active-high core reset.
- o_state  out  3  IDLE=0, PRE=1, RUN=2, STEP=3, HALT=4.
- o_instr_count  out  CNT_W  instructions retired since last PRE.
- o_bp_hit  out  1  sticky breakpoint-halt flag.

Behaviour:
- Async reset (i_rst_n=0): state=IDLE, hold counter=0, o_instr_count=0, o_bp_hit=0, skip flag=0, start-mode flag=0. Takes effect immediately, including mid-RUN.
- State, counters and flags are registered. o_clk_enable and o_core_rst are combinational from state, i_pc and the skip flag.
- o_core_rst=1 in IDLE and PRE, else 0.
- o_clk_enable:
  - RUN: 1 unless bp_match.
  - STEP: 1.
  - All other states: 0.
- bp_match = i_bp_en & (i_pc==i_bp_addr) & ~skip.
- Transition priority per cycle: clear > bp_match > run > step.
- IDLE:
  - run -> PRE with mode=RUN.
  - step -> PRE with mode=STEP.
  - run and step together -> mode=RUN.
  - On entry to PRE: o_instr_count<=0, o_bp_hit<=0.
- PRE:
  - Hold counter counts 0..RESET_HOLD-1, then -> RUN or STEP per mode. PRE lasts exactly RESET_HOLD cycles.
  - run/step ignored. clear -> IDLE.
- RUN:
  - bp_match -> HALT and set o_bp_hit. No instruction executes that cycle.
  - Else run -> HALT. The instruction in the pulse cycle still executes (enable=1).
  - step ignored.
- STEP: exactly one cycle, enable=1 regardless of breakpoint, -> HALT.
- HALT:
  - run -> RUN, set skip, clear o_bp_hit.
  - step -> STEP, clear o_bp_hit.
  - Both together -> RUN.
  - clear -> IDLE.
- Skip flag: set on HALT->RUN. Cleared after the first RUN cycle with enable=1. This lets the instruction at the breakpoint execute on resume.
- o_instr_count: +1 on every cycle with o_clk_enable=1 & o_core_rst=0. Saturates at all-ones, no wrap. Holds value in HALT and IDLE until the next PRE entry.
- i_bp_en or i_bp_addr changing mid-RUN takes effect the same cycle.
- clear in any state -> IDLE next cycle. o_core_rst rises that cycle; o_bp_hit is cleared.

Test Plan:
- Reset release, no buttons -> o_state=0, o_core_rst=1, o_clk_enable=0, count=0 indefinitely.
- run pulse in IDLE, RESET_HOLD=4 -> o_core_rst=1 for 4 cycles (state 1), then state=2, o_clk_enable=1; after 10 cycles count=10. A second run pulse -> state=4 one cycle later, with count=11 (pulse cycle executed).
- bp_en=1, bp_addr=0x10, PC steps by 4 from 0 -> halt with i_pc=0x10, count=4, o_bp_hit=1. Then run -> instruction at 0x10 executes, no re-halt; o_bp_hit=0.
- HALT then three step pulses spaced 5 cycles apart -> exactly three single-cycle enable pulses, count +3, state returns to 4 each time. step pressed with i_pc==bp_addr still executes.
- step pulse from IDLE -> PRE for RESET_HOLD cycles, one enabled cycle, HALT with count=1. Simultaneous run+step in HALT -> RUN.
- clear during RUN -> next cycle state=0, o_core_rst=1; count holds its value until next run, then 0 on PRE entry. Asserting i_rst_n=0 mid-STEP -> immediate IDLE, all outputs at reset values.
